// File: rtl/vt_seq_detect_ctrl.sv
// Run controller for a frame-aligned, non-overlapping serial pattern detector.
// Slices the qualified serial stream into FRAME_LEN-bit frames, counts frames/matches, auto-halts on limit.
module vt_seq_detect_ctrl #(
  parameter int                   FRAME_LEN       = 6,
  parameter int                   CNT_W           = 8,
  parameter logic [FRAME_LEN-1:0] DEFAULT_PATTERN = 6'b100110
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  input  logic [FRAME_LEN-1:0] i_cfg_pattern,
  output logic                 o_cfg_ready,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [CNT_W-1:0]     i_match_limit,
  input  logic                 i_SI,
  input  logic                 i_SI_valid,
  output logic                 o_f,
  output logic                 o_done,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_match_cnt,
  output logic [CNT_W-1:0]     o_frame_cnt
);

  // state | meaning
  // IDLE  | disarmed; pattern may be reconfigured
  // RUN   | framing and comparing qualified serial bits
  // HALT  | match limit reached; waiting for start or stop
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] pattern_q, pattern_d;
  logic [FRAME_LEN-2:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]     limit_q, limit_d;
  logic                 f_q, f_d;
  logic                 done_q, done_d;

  logic [FRAME_LEN-1:0] frame;
  logic [CNT_W-1:0]     match_inc;
  logic [CNT_W-1:0]     frame_inc;

  assign frame     = {shift_q, i_SI};
  assign match_inc = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
  assign frame_inc = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pattern_q   <= DEFAULT_PATTERN;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
      frame_cnt_q <= '0;
      limit_q     <= '0;
      f_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      match_cnt_q <= match_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      limit_q     <= limit_d;
      f_q         <= f_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    match_cnt_d = match_cnt_q;
    frame_cnt_d = frame_cnt_q;
    limit_d     = limit_q;
    f_d         = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cfg_valid) pattern_d = i_cfg_pattern;
        if (i_start && !i_stop) begin
          state_d     = RUN;
          shift_d     = '0;
          bit_idx_d   = '0;
          match_cnt_d = '0;
          frame_cnt_d = '0;
          limit_d     = i_match_limit;
        end
      end
      RUN: begin
        // Stop discards any partial frame, even one completing on this edge.
        if (i_stop) begin
          state_d   = IDLE;
          shift_d   = '0;
          bit_idx_d = '0;
        end else if (i_SI_valid) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d   = '0;
            shift_d     = '0;
            frame_cnt_d = frame_inc;
            if (frame == pattern_q) begin
              match_cnt_d = match_inc;
              f_d         = 1'b1;
              if ((limit_q != '0) && (match_inc == limit_q)) begin
                done_d  = 1'b1;
                state_d = HALT;
              end
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = frame[FRAME_LEN-2:0];
          end
        end
      end
      HALT: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (i_start) begin
          state_d     = RUN;
          shift_d     = '0;
          bit_idx_d   = '0;
          match_cnt_d = '0;
          frame_cnt_d = '0;
          limit_d     = i_match_limit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_cfg_ready = (state_q == IDLE);
  assign o_busy      = (state_q == RUN);
  assign o_f         = f_q;
  assign o_done      = done_q;
  assign o_match_cnt = match_cnt_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vt_seq_detect_ctrl.sv
// Bench for vt_seq_detect_ctrl: frame table applied in a loop with a scoreboard queue,
// plus hand-written sequences for config, stop and reset corner cases.
module tb_vt_seq_detect_ctrl;
  localparam int FL = 6;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_cfg_valid, i_start, i_stop, i_SI, i_SI_valid;
  logic [FL-1:0] i_cfg_pattern;
  logic [CW-1:0] i_match_limit;
  logic          o_cfg_ready, o_f, o_done, o_busy;
  logic [CW-1:0] o_match_cnt, o_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  vt_seq_detect_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_valid(i_cfg_valid), .i_cfg_pattern(i_cfg_pattern), .o_cfg_ready(o_cfg_ready),
    .i_start(i_start), .i_stop(i_stop), .i_match_limit(i_match_limit),
    .i_SI(i_SI), .i_SI_valid(i_SI_valid),
    .o_f(o_f), .o_done(o_done), .o_busy(o_busy),
    .o_match_cnt(o_match_cnt), .o_frame_cnt(o_frame_cnt)
  );

  typedef struct {
    logic f;
    logic done;
    logic [CW-1:0] match;
    logic [CW-1:0] frame;
    logic busy;
  } exp_t;

  // start_mode: 0 = none, 1 = stop then start, 2 = start only
  typedef struct {
    int            start_mode;
    logic [CW-1:0] limit;
    logic [FL-1:0] data;
    logic          gaps;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_stop(input logic with_start);
    i_stop = 1'b1;
    i_start = with_start;
    step();
    i_stop = 1'b0;
    i_start = 1'b0;
    check("stop_busy", 32'(o_busy), 32'd0);
    check("stop_cfg_ready", 32'(o_cfg_ready), 32'd1);
  endtask

  task automatic do_start(input logic [CW-1:0] lim);
    i_start = 1'b1;
    i_match_limit = lim;
    step();
    i_start = 1'b0;
    i_match_limit = 8'd1;  // limit must have been latched, not read live
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_match_cnt", 32'(o_match_cnt), 32'd0);
    check("start_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("start_cfg_ready", 32'(o_cfg_ready), 32'd0);
  endtask

  task automatic cfg_write(input logic [FL-1:0] p);
    i_cfg_valid = 1'b1;
    i_cfg_pattern = p;
    step();
    i_cfg_valid = 1'b0;
  endtask

  task automatic feed_bits(input logic [FL-1:0] d, input int nbits);
    for (int i = FL - 1; i >= FL - nbits; i--) begin
      i_SI = d[i];
      i_SI_valid = 1'b1;
      step();
    end
    i_SI_valid = 1'b0;
  endtask

  task automatic feed_frame(input logic [FL-1:0] d, input logic gaps);
    exp_t e;
    for (int i = FL - 1; i >= 0; i--) begin
      if (gaps) begin
        i_SI_valid = 1'b0;
        i_SI = ~d[i];
        step();
        check("gap_f", 32'(o_f), 32'd0);
      end
      i_SI = d[i];
      i_SI_valid = 1'b1;
      step();
    end
    i_SI_valid = 1'b0;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: actual empty required entry");
    end else begin
      e = sb_q.pop_front();
      check("frame_f", 32'(o_f), 32'(e.f));
      check("frame_done", 32'(o_done), 32'(e.done));
      check("frame_match_cnt", 32'(o_match_cnt), 32'(e.match));
      check("frame_frame_cnt", 32'(o_frame_cnt), 32'(e.frame));
      check("frame_busy", 32'(o_busy), 32'(e.busy));
      step();
      check("f_one_cycle", 32'(o_f), 32'd0);
      check("done_one_cycle", 32'(o_done), 32'd0);
    end
  endtask

  task automatic expect_frame(input logic f, input logic done, input logic [CW-1:0] m,
                              input logic [CW-1:0] fr, input logic busy);
    exp_t e;
    e.f = f; e.done = done; e.match = m; e.frame = fr; e.busy = busy;
    sb_q.push_back(e);
  endtask

  initial begin
    vecs[0] = '{1, 8'd0, 6'b100110, 1'b0, '{1'b1, 1'b0, 8'd1, 8'd1, 1'b1}};
    vecs[1] = '{1, 8'd0, 6'b100100, 1'b0, '{1'b0, 1'b0, 8'd0, 8'd1, 1'b1}};
    vecs[2] = '{0, 8'd0, 6'b110011, 1'b0, '{1'b0, 1'b0, 8'd0, 8'd2, 1'b1}};
    vecs[3] = '{0, 8'd0, 6'b100110, 1'b0, '{1'b1, 1'b0, 8'd1, 8'd3, 1'b1}};
    vecs[4] = '{1, 8'd0, 6'b100110, 1'b1, '{1'b1, 1'b0, 8'd1, 8'd1, 1'b1}};
    vecs[5] = '{1, 8'd2, 6'b100110, 1'b0, '{1'b1, 1'b0, 8'd1, 8'd1, 1'b1}};
    vecs[6] = '{0, 8'd2, 6'b100110, 1'b0, '{1'b1, 1'b1, 8'd2, 8'd2, 1'b0}};
    vecs[7] = '{0, 8'd2, 6'b100110, 1'b0, '{1'b0, 1'b0, 8'd2, 8'd2, 1'b0}};
    vecs[8] = '{2, 8'd2, 6'b100110, 1'b0, '{1'b1, 1'b0, 8'd1, 8'd1, 1'b1}};

    i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_pattern = '0; i_start = 1'b0; i_stop = 1'b0;
    i_match_limit = '0; i_SI = 1'b0; i_SI_valid = 1'b0;
    step();
    step();
    i_rst = 1'b0;
    check("rst_f", 32'(o_f), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
    check("rst_match_cnt", 32'(o_match_cnt), 32'd0);
    check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);

    // Framing, realignment, gaps, limit/halt and restart from HALT
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].start_mode == 1) do_stop(1'b0);
      if (vecs[v].start_mode != 0) do_start(vecs[v].limit);
      sb_q.push_back(vecs[v].e);
      feed_frame(vecs[v].data, vecs[v].gaps);
    end

    // Config in IDLE accepted, ignored in RUN
    do_stop(1'b0);
    cfg_write(6'b010101);
    do_start(8'd0);
    expect_frame(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    feed_frame(6'b010101, 1'b0);
    i_cfg_valid = 1'b1;
    i_cfg_pattern = 6'b111111;
    #1;
    check("run_cfg_ready", 32'(o_cfg_ready), 32'd0);
    step();
    i_cfg_valid = 1'b0;
    expect_frame(1'b1, 1'b0, 8'd2, 8'd2, 1'b1);
    feed_frame(6'b010101, 1'b0);
    expect_frame(1'b0, 1'b0, 8'd2, 8'd3, 1'b1);
    feed_frame(6'b111111, 1'b0);

    // Stop mid-frame (with a coincident start), then clean restart
    do_stop(1'b0);
    cfg_write(6'b100110);
    do_start(8'd0);
    expect_frame(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    feed_frame(6'b100110, 1'b0);
    feed_bits(6'b100110, 3);
    i_SI = 1'b1; i_SI_valid = 1'b1;
    do_stop(1'b1);
    i_SI_valid = 1'b0;
    check("stop_hold_match", 32'(o_match_cnt), 32'd1);
    check("stop_hold_frame", 32'(o_frame_cnt), 32'd1);
    check("stop_no_f", 32'(o_f), 32'd0);
    do_start(8'd0);
    expect_frame(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    feed_frame(6'b100110, 1'b0);

    // Stop coinciding with a completing matching edge wins
    feed_bits(6'b100110, 5);
    i_SI = 1'b0; i_SI_valid = 1'b1; i_stop = 1'b1;
    step();
    i_SI_valid = 1'b0; i_stop = 1'b0;
    check("stopedge_f", 32'(o_f), 32'd0);
    check("stopedge_match", 32'(o_match_cnt), 32'd1);
    check("stopedge_frame", 32'(o_frame_cnt), 32'd1);
    check("stopedge_busy", 32'(o_busy), 32'd0);

    // Reset mid-frame reverts the pattern to the default
    cfg_write(6'b111000);
    do_start(8'd0);
    expect_frame(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    feed_frame(6'b111000, 1'b0);
    feed_bits(6'b111000, 2);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mrst_f", 32'(o_f), 32'd0);
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_cfg_ready", 32'(o_cfg_ready), 32'd1);
    check("mrst_match_cnt", 32'(o_match_cnt), 32'd0);
    check("mrst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    do_start(8'd0);
    expect_frame(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    feed_frame(6'b100110, 1'b0);
    expect_frame(1'b0, 1'b0, 8'd1, 8'd2, 1'b1);
    feed_frame(6'b111000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
